// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared seven-segment definitions for the LFSR sampler slice.
//            Segment vectors are active-low, bit order {g,f,e,d,c,b,a}
//            (bit0 = a ... bit6 = g).
// Contents : seg_t, SEG_0 .. SEG_F, SEG_BLANK, DATA_W
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int DATA_W = 8;

    typedef logic [6:0] seg_t;

    // Active-low: a 0 bit lights the segment.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;  // lower-case b
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;  // lower-case d
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/lfsr_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_sampler_if
// Purpose  : Valid/ready byte stream carrying captured LFSR samples.
// Signals  : out_valid - head entry valid (producer -> consumer)
//            out_ready - consumer accepts head (consumer -> producer)
//            out_data  - head byte (producer -> consumer)
// Modports : master (producer side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface lfsr_sampler_if;
    import seg7_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Purpose  : Combinational hex nibble to active-low seven-segment decode.
//            A-F are shown as A b C d E F.
// Ports    : i_nibble [3:0] - value to display
//            o_seg    [6:0] - active-low segments, bit0 = a ... bit6 = g
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output seg_t            o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_sampler.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_sampler
// Purpose  : Samples a free-running LFSR byte on each debounced button press,
//            displays the capture on two hex digits and queues non-zero
//            captures in a DEPTH-entry FIFO on a valid/ready stream.
//            Flags LFSR lock-up (0x00 capture) and dropped captures.
// Params   : DEBOUNCE_CYCLES - stable cycles before btn_db follows (1..255)
//            DEPTH           - FIFO entries, power of two, >= 2
// Ports    : clk, reset      - clock, synchronous active-high reset
//            lfsr_in  [7:0]  - LFSR value to sample
//            btn             - raw asynchronous push-button
//            strm            - master stream (out_valid/out_ready/out_data)
//            seg0/seg1[6:0]  - active-low low/high nibble digits
//            sample_cnt[7:0] - accepted captures, wrapping
//            overflow        - sticky, capture dropped on full FIFO
//            lock_err        - sticky, a 0x00 value was captured
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_sampler
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 4
)(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [7:0]  lfsr_in,
    input  wire logic        btn,
    lfsr_sampler_if.master   strm,
    output seg_t             seg0,
    output seg_t             seg1,
    output logic [7:0]       sample_cnt,
    output logic             overflow,
    output logic             lock_err
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam logic [7:0] c_DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Left without reset so the flops keep tracking
    // the pin during reset; a button held through reset is then seen as
    // high immediately afterwards and handled by the arming logic below.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_btn_s;

    always_ff @(posedge clk) begin
        r_sync1 <= btn;
        r_btn_s <= r_sync1;
    end

    // ------------------------------------------------------------------
    // Debouncer and press detect
    // ------------------------------------------------------------------
    logic       r_btn_db;
    logic       r_btn_db_d;
    logic       r_armed;
    logic [7:0] r_db_cnt;
    logic       w_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_db_cnt   <= 8'd0;
            r_armed    <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= 8'd0;
            end else if (r_db_cnt == c_DB_LAST) begin
                // DEBOUNCE_CYCLES consecutive differing cycles seen
                r_btn_db <= r_btn_s;
                r_db_cnt <= 8'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
            // Presses are only honoured once the button has been seen
            // released since reset, so a press straddling reset is ignored.
            if (!r_btn_db && !r_btn_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_press = r_btn_db & ~r_btn_db_d & r_armed;

    // ------------------------------------------------------------------
    // FIFO: extra pointer MSB distinguishes full from empty
    // ------------------------------------------------------------------
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [7:0]    r_mem [DEPTH];
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_zero;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign strm.out_valid = ~w_empty;
    assign strm.out_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_pop      = ~w_empty & strm.out_ready;
    assign w_zero     = w_press && (lfsr_in == 8'h00);
    assign w_push_req = w_press && (lfsr_in != 8'h00);
    // A full FIFO frees its head slot when it pops in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage is cleared on reset so out_data reads 0x00 while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= lfsr_in;
        end
    end

    // ------------------------------------------------------------------
    // Capture register, counter and sticky flags
    // ------------------------------------------------------------------
    logic [7:0] r_hold;
    logic [7:0] r_sample_cnt;
    logic       r_overflow;
    logic       r_lock_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold       <= 8'h00;
            r_sample_cnt <= 8'd0;
            r_overflow   <= 1'b0;
            r_lock_err   <= 1'b0;
        end else begin
            if (w_press) begin
                r_hold <= lfsr_in;
            end
            if (w_push) begin
                r_sample_cnt <= r_sample_cnt + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_zero) begin
                r_lock_err <= 1'b1;
            end
        end
    end

    assign sample_cnt = r_sample_cnt;
    assign overflow   = r_overflow;
    assign lock_err   = r_lock_err;

    // ------------------------------------------------------------------
    // Display: registered decode of the held byte
    // ------------------------------------------------------------------
    seg_t w_seg_lo;
    seg_t w_seg_hi;
    seg_t r_seg0;
    seg_t r_seg1;

    hex_to_seg7 u_seg_lo (
        .i_nibble (r_hold[3:0]),
        .o_seg    (w_seg_lo)
    );

    hex_to_seg7 u_seg_hi (
        .i_nibble (r_hold[7:4]),
        .o_seg    (w_seg_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg0 <= SEG_0;
            r_seg1 <= SEG_0;
        end else begin
            r_seg0 <= w_seg_lo;
            r_seg1 <= w_seg_hi;
        end
    end

    assign seg0 = r_seg0;
    assign seg1 = r_seg1;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_sampler
// Purpose  : Self-checking bench for lfsr_sampler. A behavioural model
//            (queue FIFO, run-length debounce, lookup-table display) is
//            compared against the DUT every cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_sampler;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic [7:0] lfsr_in;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [7:0] sample_cnt;
    logic       overflow;
    logic       lock_err;

    lfsr_sampler_if strm ();

    lfsr_sampler #(
        .DEBOUNCE_CYCLES (D),
        .DEPTH           (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lfsr_in    (lfsr_in),
        .btn        (btn),
        .strm       (strm),
        .seg0       (seg0),
        .seg1       (seg1),
        .sample_cnt (sample_cnt),
        .overflow   (overflow),
        .lock_err   (lock_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-low {g,f,e,d,c,b,a} digit shapes
    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit         m_sync1  = 1'b0;
    bit         m_btn_s  = 1'b0;
    bit         m_db     = 1'b0;
    bit         m_db_d   = 1'b0;
    bit         m_armed  = 1'b0;
    int         m_run    = 0;
    logic [7:0] m_hold   = 8'h00;
    logic [7:0] m_disp   = 8'h00;
    logic [7:0] m_q [$];
    int         m_cnt    = 0;
    bit         m_ovf    = 1'b0;
    bit         m_lock   = 1'b0;

    always @(negedge clk) begin : model
        bit press;
        bit pop;
        bit arm_now;

        chk("valid", strm.out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("data", strm.out_data, m_q[0]);
        end
        chk("seg0", seg0, exp_seg(m_disp[3:0]));
        chk("seg1", seg1, exp_seg(m_disp[7:4]));
        chk("cnt", sample_cnt, m_cnt[7:0]);
        chk("overflow", overflow, m_ovf);
        chk("lock_err", lock_err, m_lock);

        if (reset) begin
            m_db = 0; m_db_d = 0; m_run = 0; m_armed = 0;
            m_hold = 0; m_disp = 0; m_q.delete();
            m_cnt = 0; m_ovf = 0; m_lock = 0;
        end else begin
            press   = m_db && !m_db_d && m_armed;
            pop     = (m_q.size() != 0) && strm.out_ready;
            arm_now = !m_db && !m_btn_s;
            m_disp  = m_hold;
            if (pop) void'(m_q.pop_front());
            if (press) begin
                m_hold = lfsr_in;
                if (lfsr_in == 8'h00) m_lock = 1;
                else if (m_q.size() < DEPTH) begin
                    m_q.push_back(lfsr_in);
                    m_cnt = (m_cnt + 1) % 256;
                end else m_ovf = 1;
            end
            m_db_d = m_db;
            if (m_btn_s != m_db) begin
                m_run++;
                if (m_run >= D) begin
                    m_db  = m_btn_s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (arm_now) m_armed = 1;
        end
        m_btn_s = m_sync1;
        m_sync1 = btn;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press_val(input logic [7:0] v);
        lfsr_in = v;
        btn = 1'b1;
        tick(D + 4);
        btn = 1'b0;
        tick(D + 4);
    endtask

    initial begin
        reset = 1'b1;
        btn = 1'b0;
        lfsr_in = 8'h00;
        strm.out_ready = 1'b0;
        tick(2);
        reset = 1'b0;

        // Reset values
        chk("rst_seg0", seg0, 7'b1000000);
        chk("rst_seg1", seg1, 7'b1000000);
        chk("rst_valid", strm.out_valid, 1'b0);
        chk("rst_cnt", sample_cnt, 8'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_lock", lock_err, 1'b0);

        // Glitch of 3 cycles is rejected
        lfsr_in = 8'h5A;
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(12);
        chk("glitch_cnt", sample_cnt, 8'd0);
        chk("glitch_valid", strm.out_valid, 1'b0);
        chk("glitch_seg0", seg0, 7'b1000000);

        // Single capture: press in cycle 6, out_valid from cycle 7
        lfsr_in = 8'hA5;
        btn = 1'b1;
        tick(6);
        chk("cap_early_valid", strm.out_valid, 1'b0);
        tick(1);
        chk("cap_valid", strm.out_valid, 1'b1);
        chk("cap_data", strm.out_data, 8'hA5);
        chk("cap_cnt", sample_cnt, 8'd1);
        tick(1);
        chk("cap_seg1", seg1, 7'b0001000);
        chk("cap_seg0", seg0, 7'b0010010);
        tick(2);
        btn = 1'b0;
        tick(10);
        strm.out_ready = 1'b1;
        tick(1);
        strm.out_ready = 1'b0;
        chk("cap_drained", strm.out_valid, 1'b0);

        // Overflow on 5th press
        do_reset();
        for (int i = 1; i <= 5; i++) press_val(8'(i));
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_cnt", sample_cnt, 8'd4);
        chk("ovf_seg0", seg0, 7'b0010010);
        chk("ovf_seg1", seg1, 7'b1000000);
        strm.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_valid", strm.out_valid, 1'b1);
            chk("ovf_pop_data", strm.out_data, 32'(i));
            tick(1);
        end
        chk("ovf_empty", strm.out_valid, 1'b0);
        strm.out_ready = 1'b0;

        // Full FIFO with simultaneous pop accepts the push
        do_reset();
        for (int i = 0; i < 4; i++) press_val(8'h11 + 8'(i));
        chk("full_cnt", sample_cnt, 8'd4);
        lfsr_in = 8'h77;
        btn = 1'b1;
        tick(6);
        strm.out_ready = 1'b1;  // press cycle, FIFO full
        chk("full_d0", strm.out_data, 8'h11);
        tick(1);
        chk("full_d1", strm.out_data, 8'h12);
        tick(1);
        chk("full_d2", strm.out_data, 8'h13);
        tick(1);
        chk("full_d3", strm.out_data, 8'h14);
        tick(1);
        chk("full_d4", strm.out_data, 8'h77);
        tick(1);
        chk("full_empty", strm.out_valid, 1'b0);
        chk("full_ovf", overflow, 1'b0);
        chk("full_cnt5", sample_cnt, 8'd5);
        btn = 1'b0;
        strm.out_ready = 1'b0;
        tick(10);

        // Lock-up value and mid-run reset with button held
        do_reset();
        press_val(8'h33);
        press_val(8'h44);
        lfsr_in = 8'h00;
        btn = 1'b1;
        tick(D + 4);
        chk("lock_flag", lock_err, 1'b1);
        chk("lock_cnt", sample_cnt, 8'd2);
        chk("lock_seg0", seg0, 7'b1000000);
        chk("lock_seg1", seg1, 7'b1000000);
        chk("lock_head", strm.out_data, 8'h33);
        reset = 1'b1;
        tick(1);
        chk("mid_valid", strm.out_valid, 1'b0);
        chk("mid_lock", lock_err, 1'b0);
        chk("mid_ovf", overflow, 1'b0);
        chk("mid_cnt", sample_cnt, 8'd0);
        tick(1);
        reset = 1'b0;
        lfsr_in = 8'h5C;
        tick(20);
        chk("held_cnt", sample_cnt, 8'd0);
        chk("held_valid", strm.out_valid, 1'b0);
        btn = 1'b0;
        tick(10);
        press_val(8'h5C);
        chk("repress_cnt", sample_cnt, 8'd1);
        chk("repress_data", strm.out_data, 8'h5C);

        // Randomized phase, checked by the model every cycle
        for (int s = 0; s < 400; s++) begin
            int len;
            btn = ~btn;
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                lfsr_in = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
                strm.out_ready = ($urandom_range(0, 2) == 0);
                reset = ($urandom_range(0, 299) == 0);
                tick(1);
            end
        end
        reset = 1'b0;
        btn = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_sampler.md
# lfsr_sampler

Downstream consumer of the `linear_shift` 8-bit LFSR. Samples the free-running `lfsr_out` value on each debounced button press, shows the captured byte on two seven-segment digits, and queues every capture in a small FIFO on a valid/ready stream. It also flags LFSR lock-up (all-zero value) and capture overflow.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced button changes state. Legal range is 1 to 255.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, at least 2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `lfsr_in`  in  8  connected to `linear_shift.lfsr_out`.
- `btn`  in  1  raw, asynchronous push-button.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  8  FIFO head byte.
- `seg0`  out  7  active-low low-nibble digit; bit0=a … bit6=g.
- `seg1`  out  7  active-low high-nibble digit.
- `sample_cnt`  out  8  number of accepted captures, wrapping.
- `overflow`  out  1  sticky; set when a capture is dropped because the FIFO is full.
- `lock_err`  out  1  sticky; set when a captured value is 0x00.

## Operation
- **Synchronizer:** `btn` passes through a two-flop synchronizer to produce `btn_s`.
- **Debounce:** an 8-bit counter resets whenever `btn_s` equals `btn_db`, and increments otherwise. When the count reaches `DEBOUNCE_CYCLES` and `btn_s` still differs, `btn_db` takes the value of `btn_s` and the counter clears.
- **Edge detect:** `press` is high for one cycle, in the first cycle `btn_db` is high (`btn_db` and not `btn_db_d`).
- **Capture:** in a `press` cycle, `lfsr_in` is written to `hold` at the end of that cycle.
  - If the captured value is 0x00, `lock_err` is set. The value is still displayed but is **not** pushed and `sample_cnt` is not incremented.
  - If the value is non-zero and the FIFO can accept it, it is pushed and `sample_cnt` increments by 1 (0xFF wraps to 0x00).
  - If the value is non-zero and the FIFO cannot accept it, it is dropped, `overflow` is set, and the count is unchanged. `hold` and the display still update.
- **FIFO:** `DEPTH` entries with read/write pointers of width clog2(`DEPTH`)+1.
  - Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - A pop occurs when `out_valid` and `out_ready` are both high.
  - A push into a full FIFO is accepted only if a pop happens in the same cycle.
  - There is no pass-through path: a push into an empty FIFO makes `out_valid` high on the next cycle.
  - `out_data` is the head entry and stays stable while `out_valid` is high and `out_ready` is low.
- **Display:** `seg1`/`seg0` are registered hex decodes of `hold[7:4]` and `hold[3:0]`, covering 0–F, with A–F shown as A b C d E F.
- **Sticky flags:** `overflow` and `lock_err` are cleared only by `reset`.
- **Reset values:** `hold`=0x00, `seg0`=`seg1`=7'b1000000 (the digit "0"), `out_valid`=0, `out_data`=0x00, `sample_cnt`=0, `overflow`=0, `lock_err`=0, FIFO empty, `btn_db`=0, debounce counter=0.
- **Mid-operation reset:** a reset asserted at any point discards queued data, any debounce in progress, and any pending press. A button held through reset must be released and pressed again to trigger a capture.

## Timing
- **Button to press:** a `btn` rise stable from cycle 0 gives `press` in cycle 2+`DEBOUNCE_CYCLES`. That is 2 cycles of synchronizer plus `DEBOUNCE_CYCLES` cycles of counting.
- **Which value is sampled:** the sampled `lfsr_in` is the value present during the `press` cycle P.
- **Capture outputs:** `hold`, the FIFO write, and `sample_cnt` update at the end of cycle P.
- **Display latency:** `seg0`/`seg1` change at the end of cycle P+1, a 2-cycle latency from press to display.
- **Stream latency:** `out_valid` is high from cycle P+1 when the FIFO was previously empty.
- **Throughput:** one pop per cycle while `out_ready` is held high.
- **Release:** the falling edge of `btn` is debounced identically but produces no event.
- **Glitch rejection:** a glitch on `btn_s` shorter than `DEBOUNCE_CYCLES` cycles has no effect.

## Structure
- **Shared package `seg7_pkg`:**
  - Active-low segment constants `SEG_0` … `SEG_F` and `SEG_BLANK` (7'b1111111).
  - The segment bit-order note (bit0=a … bit6=g).
- **Sub-module `hex_to_seg7`:** combinational, 4-bit in, 7-bit out. It is instantiated twice and registered in `lfsr_sampler`.
- **Inline logic:** the FIFO, debouncer, and synchronizer stay inline in `lfsr_sampler`.

## Test plan
- **Reset values:** hold `reset` for 2 cycles, then release. Required: `seg0`=`seg1`=7'b1000000, `out_valid`=0, `sample_cnt`=0, `overflow`=0, `lock_err`=0.
- **Single capture:** `DEBOUNCE_CYCLES`=4, `lfsr_in` driven constant at 0xA5, `btn` held high for 10 cycles.
  - `out_valid` rises 7 cycles after the `btn` rise, with `out_data`=0xA5.
  - `seg1`=A (7'b0001000) and `seg0`=5 (7'b0010010).
  - `sample_cnt`=1.
- **Glitch rejection:** `btn` high for 3 cycles, then low. Required: no capture, `sample_cnt`=0, `out_valid`=0.
- **Overflow:** `DEPTH`=4, `out_ready`=0, 5 presses with values 0x01 … 0x05.
  - After the 5th press: `overflow`=1, `sample_cnt`=4, and `seg0` shows 5.
  - Popping with `out_ready`=1 then yields 0x01, 0x02, 0x03, 0x04 on consecutive cycles, followed by `out_valid`=0.
- **Full with simultaneous pop:** FIFO full, `out_ready`=1 held, press with 0x77. Required: the push is accepted, `overflow` stays 0, and 0x77 emerges after the 4 older entries.
- **Lock-up and mid-run reset:**
  - Press with `lfsr_in`=0x00: `lock_err`=1, nothing pushed, display shows "00".
  - Then assert `reset` with 2 entries queued: `out_valid`=0, and all flags and counts return to 0 on the following cycle.
